uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
- Memory-mapped controller that sequences the uart_tx serializer for the cpu.
- Byte writes to TX_ADDR go into a small FIFO. The FIFO is drained into uart_tx using its start/ready handshake.
- Processor is held with a clean stall output only when the FIFO is full. This replaces gating the processor clock during transmission.
- Sits between the cpu data-memory bus and uart_tx, alongside data_memory.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- TX_ADDR, 32'h2001: write-only data register address.
- STATUS_ADDR, 32'h2002: read-only status register address.
- SYNC_READY, 1: 1 = 2-flop synchronizer on uart_ready (uart_tx on another clock); 0 = use uart_ready directly.
- BUSY_TIMEOUT, 64: cycles to wait for uart_ready to fall after start.

Ports:
- clk  in  1  block clock
- rst  in  1  asynchronous, active-high reset
- bus_addr  in  32  data-memory address from cpu
- bus_wdata  in  32  write data; only bits [7:0] are used
- bus_write  in  1  write strobe
- bus_read  in  1  read strobe
- bus_rdata  out  32  status read data
- stall  out  1  hold processor; combinational
- uart_data  out  8  byte to uart_tx
- uart_start  out  1  start request to uart_tx
- uart_ready  in  1  uart_tx idle/ready
- irq  out  1  drain-complete pulse (optional feature)

Behaviour:
- Reset (async, rst=1):
  - FIFO empty, state IDLE.
  - uart_start=0, uart_data=0, stall=0, bus_rdata=0, irq=0, tx_err=0, ready_s=0.
  - A byte already inside uart_tx is not aborted.
- Push:
  - Condition: bus_write && bus_addr==TX_ADDR && !full.
  - Enqueues bus_wdata[7:0] at the clk edge.
- Stall:
  - stall = bus_write && bus_addr==TX_ADDR && full.
  - While stalled, no enqueue occurs. The push completes in the first cycle full deasserts.
- Simultaneous push and pop: count is unchanged; the FIFO must never drop or duplicate a byte.
- Full/empty are derived from a count of width clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Status read (combinational):
  - Active when bus_read && bus_addr==STATUS_ADDR; all other reads return 0.
  - bit0 = empty, bit1 = full, bit2 = busy (state != IDLE), bit3 = tx_err, bits[15:8] = count.
  - tx_err clears at the clk edge of a status read. If a new error occurs in the same cycle, the set wins.
- Writes to STATUS_ADDR are ignored.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if !empty && ready_s, then at the next edge: pop head, uart_data <= head, uart_start <= 1, timeout counter cleared, go to WAIT_BUSY.
  - WAIT_BUSY: uart_start stays 1.
    - If ready_s==0: uart_start <= 0, go to WAIT_DONE.
    - Else, if the counter reaches BUSY_TIMEOUT-1: uart_start <= 0, tx_err <= 1, go to IDLE. The byte is discarded.
  - WAIT_DONE: when ready_s==1, go to IDLE.
- Latency: push sampled at edge E0 with FIFO empty, state IDLE and ready_s=1 gives uart_start high after edge E1.
- Back-to-back bytes: the next pop happens no earlier than the edge after WAIT_DONE returns to IDLE.
- ready_s is uart_ready after 2 flops (SYNC_READY=1) or uart_ready directly (SYNC_READY=0).
- uart_data stays stable from start assertion until the next pop.

Optional Feature:
- Macro: UART_TX_CTRL_IRQ_EN.
- Defined: irq is a registered 1-cycle pulse on the edge where the FSM enters IDLE from WAIT_DONE while the FIFO is empty.
- Undefined: irq is tied to 0 and no irq logic is present.

Decomposition:
- Package uart_tx_ctrl_pkg holds:
  - state encoding constants (IDLE=2'd0, WAIT_BUSY=2'd1, WAIT_DONE=2'd2);
  - status bit indices;
  - default TX_ADDR and STATUS_ADDR.
- Sub-module sync_fifo (WIDTH=8, DEPTH): push/pop/full/empty/count plus a head output.
- The FSM, synchronizer and bus decode stay in uart_tx_ctrl.

Test Plan:
- Reset, then one write 0x41 to 0x2001 with ready stub: uart_start rises one cycle after the write edge (SYNC_READY=0); uart_data=0x41; start drops the cycle after ready falls; busy clears after ready rises.
- Five writes 0x30..0x34 at DEPTH=4 with ready low: first four enqueue; stall=1 on the fifth until the first pop; output order is 0x30..0x34 with no loss.
- uart_ready stuck high after start for 64 cycles: uart_start drops, status bit3=1; next status read returns bit3=1, then the following read returns bit3=0; the FSM serves the next byte.
- rst asserted mid WAIT_BUSY with 3 bytes queued: uart_start=0 immediately; status reads 0x00000001 after release; no further starts.
- Push and pop in the same cycle at count=2: count stays 2, and the full sequence is 0x55, 0xAA, 0x0F in order.
- With UART_TX_CTRL_IRQ_EN: one write, full handshake completes, irq is high for exactly one cycle; without the macro, irq is 0 throughout.

Source files
------------

// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the uart_tx controller: FSM state encoding,
// status register bit positions, default register addresses and a
// helper that packs the status word.
package uart_tx_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_e;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_ERR     = 3;
  localparam int STAT_CNT_LSB = 8;

  localparam logic [31:0] DEF_TX_ADDR     = 32'h2001;
  localparam logic [31:0] DEF_STATUS_ADDR = 32'h2002;

  // Status word layout: flags in the low nibble, FIFO count in bits [15:8].
  function automatic logic [31:0] pack_status(input logic       empty,
                                              input logic       full,
                                              input logic       busy,
                                              input logic       err,
                                              input logic [7:0] count);
    logic [31:0] s;
    s                       = '0;
    s[STAT_EMPTY]           = empty;
    s[STAT_FULL]            = full;
    s[STAT_BUSY]            = busy;
    s[STAT_ERR]             = err;
    s[STAT_CNT_LSB +: 8]    = count;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_fifo.sv
// sync_fifo: single-clock FIFO with a registered occupancy count.
// Full/empty come from the count so that pointer equality is never
// ambiguous; pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Overflow/underflow requests are dropped here as a second line of defence.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Storage array; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and count; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: memory-mapped front end for the uart_tx serializer.
// CPU byte writes to TX_ADDR are queued in a FIFO and drained into uart_tx;
// the CPU is stalled only while it writes TX_ADDR with the FIFO full.
// Optional drain-complete interrupt: define UART_TX_CTRL_IRQ_EN.
//
// Handshake with uart_tx: uart_start is a level request that rises with
// uart_data loaded; uart_tx acknowledges by dropping uart_ready, at which
// point uart_start is withdrawn; the byte is finished when uart_ready rises
// again. If uart_ready never drops within BUSY_TIMEOUT cycles the request is
// abandoned, the byte discarded and tx_err latched for software.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int          DEPTH        = 4,
  parameter logic [31:0] TX_ADDR      = DEF_TX_ADDR,
  parameter logic [31:0] STATUS_ADDR  = DEF_STATUS_ADDR,
  parameter bit          SYNC_READY   = 1'b1,
  parameter int          BUSY_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_write,
  input  logic        bus_read,
  output logic [31:0] bus_rdata,
  output logic        stall,
  output logic [7:0]  uart_data,
  output logic        uart_start,
  input  logic        uart_ready,
  output logic        irq
);

  localparam int            CW       = $clog2(DEPTH) + 1;
  localparam int            TW       = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

  tx_state_e       state;
  tx_state_e       state_d;
  logic            ready_s;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [7:0]      fifo_head;
  logic            push_req;
  logic            push;
  logic            pop;
  logic            status_rd;
  logic            start_d;
  logic [7:0]      data_d;
  logic [TW-1:0]   tmo_cnt;
  logic [TW-1:0]   tmo_d;
  logic            err_set;
  logic            tx_err;
  logic            unused_wdata;

  // Only the low byte of the write data is a character.
  assign unused_wdata = ^bus_wdata[31:8];

  // Bus decode: stall holds the CPU write until the FIFO has room.
  assign push_req  = bus_write && (bus_addr == TX_ADDR);
  assign push      = push_req && !fifo_full;
  assign stall     = push_req && fifo_full;
  assign status_rd = bus_read && (bus_addr == STATUS_ADDR);

  // Status read is combinational; any other read returns zero.
  assign bus_rdata = status_rd ? pack_status(fifo_empty, fifo_full, (state != IDLE),
                                             tx_err, 8'(fifo_count))
                               : '0;

  generate
    if (SYNC_READY) begin : g_sync
      logic [1:0] sync_ff;
      // Two-flop synchronizer for uart_ready coming from the uart_tx clock.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_ff <= 2'b00;
        else     sync_ff <= {sync_ff[0], uart_ready};
      end
      assign ready_s = sync_ff[1];
    end else begin : g_direct
      assign ready_s = uart_ready;
    end
  endgenerate

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus_wdata[7:0]),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-state, start/data and timeout-counter decisions for the drain FSM.
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    start_d = uart_start;
    data_d  = uart_data;
    tmo_d   = tmo_cnt;
    err_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty && ready_s) begin
          pop     = 1'b1;
          data_d  = fifo_head;
          start_d = 1'b1;
          tmo_d   = '0;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!ready_s) begin
          start_d = 1'b0;
          state_d = WAIT_DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          start_d = 1'b0;
          err_set = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_cnt + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (ready_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, uart outputs, timeout counter and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      uart_start <= 1'b0;
      uart_data  <= '0;
      tmo_cnt    <= '0;
      tx_err     <= 1'b0;
    end else begin
      state      <= state_d;
      uart_start <= start_d;
      uart_data  <= data_d;
      tmo_cnt    <= tmo_d;
      if (err_set)        tx_err <= 1'b1;
      else if (status_rd) tx_err <= 1'b0;
    end
  end

`ifdef UART_TX_CTRL_IRQ_EN
  // One-cycle pulse when the last queued byte has finished on the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= (state == WAIT_DONE) && (state_d == IDLE) && fifo_empty;
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl (DEPTH=4, SYNC_READY=0, BUSY_TIMEOUT=64) with a
// reactive uart_tx stub and a queue-based reference model.
module tb_uart_tx_ctrl;

  localparam int          DEPTH = 4;
  localparam int          TMO   = 64;
  localparam logic [31:0] TXA   = 32'h2001;
  localparam logic [31:0] STA   = 32'h2002;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic        bus_write = 1'b0;
  logic        bus_read = 1'b0;
  logic [31:0] bus_rdata;
  logic        stall;
  logic [7:0]  uart_data;
  logic        uart_start;
  logic        uart_ready = 1'b1;
  logic        irq;

  always #5 clk = ~clk;

  uart_tx_ctrl #(
    .DEPTH        (DEPTH),
    .TX_ADDR      (TXA),
    .STATUS_ADDR  (STA),
    .SYNC_READY   (1'b0),
    .BUSY_TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_write  (bus_write),
    .bus_read   (bus_read),
    .bus_rdata  (bus_rdata),
    .stall      (stall),
    .uart_data  (uart_data),
    .uart_start (uart_start),
    .uart_ready (uart_ready),
    .irq        (irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- uart_tx stub ----------------
  bit         stub_hold_low = 1'b0;
  bit         stub_stuck    = 1'b0;
  int         stub_busy_len = 0;
  int         stub_delay_left = 0;
  int         stub_busy_left  = 0;
  logic [7:0] rx_q[$];
  logic [7:0] rx_all[$];

  always @(negedge clk) begin
    if (stub_hold_low) begin
      uart_ready = 1'b0;
    end else if (stub_busy_left > 0) begin
      stub_busy_left--;
      if (stub_busy_left == 0) uart_ready = 1'b1;
    end else if (stub_delay_left > 0) begin
      stub_delay_left--;
      if (stub_delay_left == 0) begin
        uart_ready = 1'b0;
        rx_q.push_back(uart_data);
        rx_all.push_back(uart_data);
        stub_busy_left = (stub_busy_len > 0) ? stub_busy_len : $urandom_range(1, 6);
      end
    end else begin
      uart_ready = 1'b1;
      if (uart_start && !stub_stuck) stub_delay_left = $urandom_range(1, 3);
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  bit         m_launch  = 1'b0;
  bit         m_in_uart = 1'b0;
  int         m_age     = 0;
  logic [7:0] m_data    = '0;
  bit         m_err     = 1'b0;
  bit         m_irq     = 1'b0;
  bit         m_wr, m_rd, m_err_new;

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s        = '0;
    s[0]     = (m_q.size() == 0);
    s[1]     = (m_q.size() == DEPTH);
    s[2]     = m_launch || m_in_uart;
    s[3]     = m_err;
    s[15:8]  = 8'(m_q.size());
    return s;
  endfunction

  // Advance the model by one clock using the inputs that were present at the
  // edge (all inputs change only on the falling edge), then compare.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      m_q.delete();
      exp_q.delete();
      rx_q.delete();
      m_launch  = 1'b0;
      m_in_uart = 1'b0;
      m_age     = 0;
      m_data    = '0;
      m_err     = 1'b0;
      m_irq     = 1'b0;
    end else begin
      m_wr      = bus_write && (bus_addr == TXA) && (m_q.size() < DEPTH);
      m_rd      = bus_read && (bus_addr == STA);
      m_err_new = 1'b0;
      m_irq     = 1'b0;
      if (m_launch) begin
        if (!uart_ready) begin
          m_launch  = 1'b0;
          m_in_uart = 1'b1;
          exp_q.push_back(m_data);
        end else if (m_age == TMO - 1) begin
          m_launch  = 1'b0;
          m_err_new = 1'b1;
        end else begin
          m_age++;
        end
      end else if (m_in_uart) begin
        if (uart_ready) begin
          m_in_uart = 1'b0;
          m_irq     = (m_q.size() == 0);
        end
      end else if (m_q.size() > 0 && uart_ready) begin
        m_data   = m_q.pop_front();
        m_launch = 1'b1;
        m_age    = 0;
      end
      if (m_wr) m_q.push_back(bus_wdata[7:0]);
      if (m_err_new) m_err = 1'b1;
      else if (m_rd) m_err = 1'b0;
    end
    while (exp_q.size() > 0 && rx_q.size() > 0)
      check("rx_byte_order", rx_q.pop_front(), exp_q.pop_front());
    check("uart_start", uart_start, m_launch);
    check("uart_data", uart_data, m_data);
    check("stall", stall, bus_write && (bus_addr == TXA) && (m_q.size() == DEPTH));
    check("bus_rdata", bus_rdata, (bus_read && bus_addr == STA) ? exp_status() : 32'h0);
`ifdef UART_TX_CTRL_IRQ_EN
    check("irq", irq, m_irq);
`else
    check("irq", irq, 1'b0);
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic write_tx(input logic [7:0] b);
    int g;
    g = 0;
    @(negedge clk);
    bus_addr  = TXA;
    bus_wdata = {24'h0, b};
    bus_write = 1'b1;
    #1;
    while (stall && g < 500) begin
      @(negedge clk);
      #1;
      g++;
    end
    check("write_stall_bound", stall, 1'b0);
    @(negedge clk);
    bus_write = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
  endtask

  task automatic bus_cycle(input logic [31:0] a, input logic w, input logic r, input logic [31:0] d);
    @(negedge clk);
    bus_addr  = a;
    bus_write = w;
    bus_read  = r;
    bus_wdata = d;
    @(negedge clk);
    bus_write = 1'b0;
    bus_read  = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
  endtask

  task automatic read_status(output logic [31:0] d);
    @(negedge clk);
    bus_addr = STA;
    bus_read = 1'b1;
    #1 d = bus_rdata;
    @(negedge clk);
    bus_read = 1'b0;
    bus_addr = '0;
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] d;
    int g;
    g = 0;
    read_status(d);
    while ((d[2] || !d[0]) && g < 400) begin
      read_status(d);
      g++;
    end
    check(name, {30'h0, d[2], d[0]}, 32'h1);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [31:0] d;
    int g, n, base;
    logic [7:0] seq5[5];
    logic [7:0] seq3[3];
    seq5 = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34};
    seq3 = '{8'h55, 8'hAA, 8'h0F};

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_uart_start", uart_start, 1'b0);
    check("rst_uart_data", uart_data, 8'h00);
    check("rst_stall", stall, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_rdata", bus_rdata, 32'h0);
    rst = 1'b0;
    read_status(d);
    check("reset_status", d, 32'h0000_0001);

    // T1: single byte latency and handshake
    stub_busy_len = 3;
    write_tx(8'h41);
    #1 check("t1_start_before", uart_start, 1'b0);
    @(posedge clk);
    #1;
    check("t1_start_latency", uart_start, 1'b1);
    check("t1_data", uart_data, 8'h41);
    g = 0;
    while (uart_ready !== 1'b0 && g < 50) begin
      @(negedge clk);
      #1;
      g++;
    end
    check("t1_ready_fell", uart_ready, 1'b0);
    check("t1_start_held", uart_start, 1'b1);
    @(posedge clk);
    #1 check("t1_start_drop", uart_start, 1'b0);
    wait_idle("t1_idle");
    check("t1_rx_last", rx_all[rx_all.size()-1], 8'h41);

    // T2: overfill with uart_ready low, stall until the first pop
    stub_busy_len = 0;
    stub_hold_low = 1'b1;
    repeat (2) @(negedge clk);
    base = rx_all.size();
    for (int i = 0; i < 4; i++) write_tx(seq5[i]);
    fork
      write_tx(seq5[4]);
      begin
        repeat (3) @(negedge clk);
        #1 check("t2_stall_full", stall, 1'b1);
        @(posedge clk);
        #2 stub_hold_low = 1'b0;
      end
    join
    wait_idle("t2_idle");
    check("t2_rx_count", rx_all.size() - base, 5);
    for (int i = 0; i < 5; i++)
      if (base + i < rx_all.size()) check("t2_rx_order", rx_all[base+i], seq5[i]);

    // T3: uart_ready stuck high -> timeout, sticky error, next byte served
    stub_stuck = 1'b1;
    write_tx(8'h77);
    #1;
    g = 0;
    while (!uart_start && g < 20) begin
      @(negedge clk);
      #1;
      g++;
    end
    n = 0;
    while (uart_start && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t3_start_cycles", n, TMO);
    read_status(d);
    check("t3_err_set", d[3], 1'b1);
    read_status(d);
    check("t3_err_clear", d[3], 1'b0);
    stub_stuck = 1'b0;
    base = rx_all.size();
    write_tx(8'h78);
    wait_idle("t3_idle");
    check("t3_rx_count", rx_all.size() - base, 1);
    check("t3_rx_last", rx_all[rx_all.size()-1], 8'h78);

    // T4: reset while waiting for uart_tx with bytes queued
    stub_stuck = 1'b1;
    for (int i = 1; i <= 4; i++) write_tx(8'(i));
    #1 check("t4_start_before", uart_start, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t4_rst_start", uart_start, 1'b0);
    check("t4_rst_data", uart_data, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    read_status(d);
    check("t4_status", d, 32'h0000_0001);
    n = 0;
    repeat (30) begin
      @(negedge clk);
      #1;
      if (uart_start) n++;
    end
    check("t4_no_start", n, 0);
    stub_stuck = 1'b0;

    // T5: push and pop in the same cycle at count=2
    stub_busy_len = 20;
    stub_hold_low = 1'b1;
    repeat (2) @(negedge clk);
    base = rx_all.size();
    write_tx(seq3[0]);
    write_tx(seq3[1]);
    @(posedge clk);
    #2 stub_hold_low = 1'b0;
    write_tx(seq3[2]);
    read_status(d);
    check("t5_status", d, 32'h0000_0204);
    wait_idle("t5_idle");
    stub_busy_len = 0;
    check("t5_rx_count", rx_all.size() - base, 3);
    for (int i = 0; i < 3; i++)
      if (base + i < rx_all.size()) check("t5_rx_order", rx_all[base+i], seq3[i]);

    // Random traffic against the model
    for (int it = 0; it < 250; it++) begin
      int op;
      stub_stuck = ($urandom_range(0, 29) == 0);
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        write_tx(8'($urandom_range(0, 255)));
      end else if (op == 6) begin
        case ($urandom_range(0, 2))
          0:       bus_cycle(STA, 1'b1, 1'b0, $urandom);
          1:       bus_cycle(32'h2000, 1'b1, 1'b0, $urandom);
          default: bus_cycle($urandom, 1'b1, 1'b0, $urandom);
        endcase
      end else if (op == 7) begin
        read_status(d);
      end else if (op == 8) begin
        bus_cycle(($urandom_range(0, 1) == 0) ? 32'h2003 : TXA, 1'b0, 1'b1, 32'h0);
      end else begin
        repeat ($urandom_range(1, 8)) @(negedge clk);
      end
    end
    stub_stuck = 1'b0;
    wait_idle("final_idle");
    repeat (4) @(negedge clk);
    check("final_drained", exp_q.size() + rx_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: actual still running required finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
